instruction_memory_loader: RTL and testbench
============================================

// Module: instruction_memory_loader
// PURPOSE
//  Writer side of the instruction-memory fetch path: takes a byte-stream program image, assembles
//  32-bit instruction words and writes them into Instruction_Memory_Thirty_Two_Bit's write port.
//  Holds the CPU (PC/regfile reset) via cpu_hold while loading; releases on successful completion.
//  Sits between the host byte link and the instruction memory, in front of the PC reset input.
// PARAMETERS
//  DEPTH      64  max instruction words accepted (header count > DEPTH -> error)
//  BASE_ADDR  0   address of first word written
//  ADDR_STEP  4   address increment per word (matches PC +4 stepping)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  start         in   1   1-cycle pulse: begin a new load
//  byte_in       in   8   stream byte
//  byte_valid    in   1   byte_in valid
//  byte_ready    out  1   loader accepts byte this cycle (transfer = byte_valid & byte_ready)
//  imem_wr_en    out  1   1-cycle write strobe to instruction memory
//  imem_wr_addr  out  32  write address
//  imem_wr_data  out  32  assembled instruction word
//  cpu_hold      out  1   1 while loading; drives CPU reset
//  done          out  1   sticky: load completed, checksum OK
//  error         out  1   sticky: bad count or checksum mismatch
// BEHAVIOUR
//  - Reset (sync, any state incl. mid-load): state=IDLE; all outputs 0; partial word, counters,
//    checksum cleared; no write issued in or after the reset cycle.
//  - Frame: CNT_HI, CNT_LO (16-bit word count N, MSB first), N x 4 bytes (MSB first), 1 checksum
//    byte = XOR of all 4N payload bytes (header excluded).
//  - States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR.
//  - IDLE/DONE/ERROR: start -> HDR_HI; clears done/error; cpu_hold=1 from next cycle.
//    start ignored in all other states.
//  - byte_ready=1 only in HDR_HI, HDR_LO, DATA, CHECK; 0 in IDLE, WRITE, DONE, ERROR.
//  - HDR_LO transfer: N>DEPTH -> ERROR; N==0 -> CHECK; else DATA. Address reg <= BASE_ADDR.
//  - DATA: shift byte into word reg ({word[23:0],byte_in}), XOR into checksum; on 4th byte -> WRITE.
//  - WRITE (exactly 1 cycle): imem_wr_en=1, addr=current, data=word; then addr+=ADDR_STEP
//    (32-bit wrap), word count++; -> CHECK if count==N else DATA.
//  - Write latency: imem_wr_en asserted the cycle after the 4th byte transfer.
//  - CHECK: checksum byte transfer; match -> DONE (done=1) else ERROR (error=1).
//  - cpu_hold=1 in HDR_HI..CHECK; 0 in IDLE/DONE/ERROR. In ERROR CPU released but error flagged.
//  - Writes already issued are not undone on ERROR.
//  - byte_valid may drop at any time; the loader waits, with no timeout.
//  - imem_wr_addr/imem_wr_data hold last values when imem_wr_en=0.
// TESTING
//  1 start; stream 00 02 8B 02 00 20 F8 40 00 01 10 -> writes (0x0,0x8B020020),(0x4,0xF8400001),
//    each 1 cycle after 4th byte; done=1, error=0, cpu_hold 1->0.
//  2 same stream, checksum 0x11 -> both writes occur, error=1, done=0, cpu_hold=0.
//  3 header 00 41 (65 > DEPTH=64) -> error=1 after CNT_LO, zero writes, byte_ready=0.
//  4 case 1 with random byte_valid gaps (0-5 idle cycles) -> identical writes/addresses, done=1.
//  5 reset asserted after 6th payload byte of case 1 -> next cycle all outputs 0, no 2nd write;
//    new start + full case-1 stream -> done=1, writes at 0x0 and 0x4.
//  6 header 00 00, checksum 00 -> no writes, done=1; checksum 01 -> error=1.

Source files
------------

// File: rtl/instruction_memory_loader.sv
// ---------------------------------------------------------------------------
// instruction_memory_loader
//
// Receives a byte-stream program image from the host link, assembles 32-bit
// instruction words (MSB first) and writes them into the instruction memory
// write port. The CPU is held in reset through cpu_hold while a load is in
// progress. The hold is released when the load finishes, whether it succeeds
// or fails.
//
// Frame: CNT_HI, CNT_LO (word count N), N x 4 payload bytes, 1 checksum byte
//        (XOR of all payload bytes, header excluded).
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   start         in   1-cycle pulse, begins a new load from IDLE/DONE/ERROR
//   byte_in       in   stream byte
//   byte_valid    in   byte_in valid
//   byte_ready    out  loader accepts a byte this cycle
//   imem_wr_en    out  1-cycle write strobe to instruction memory
//   imem_wr_addr  out  write address (held between strobes)
//   imem_wr_data  out  assembled instruction word (held between strobes)
//   cpu_hold      out  1 while a load is in progress
//   done          out  sticky: load completed with a good checksum
//   error         out  sticky: word count too large or checksum mismatch
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, CPU running
// HDR_HI  | waiting for the count high byte
// HDR_LO  | waiting for the count low byte, range check on N
// DATA    | collecting the 4 bytes of the current word
// WRITE   | write strobe active, advance the address and word count
// CHECK   | waiting for the checksum byte
// DONE    | load good, CPU released
// ERROR   | load bad, CPU released, error flagged
// ---------------------------------------------------------------------------
module instruction_memory_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [31:0] addr;
  logic [7:0]  csum;
  logic        xfer;
  logic [15:0] hdr_count;

  // Both outputs are decodes of the registered state, so they carry no
  // combinational path from the inputs.
  assign byte_ready = (state == ST_HDR_HI) || (state == ST_HDR_LO) ||
                      (state == ST_DATA)   || (state == ST_CHECK);
  assign cpu_hold   = (state == ST_HDR_HI) || (state == ST_HDR_LO) ||
                      (state == ST_DATA)   || (state == ST_WRITE)  ||
                      (state == ST_CHECK);

  assign xfer      = byte_valid && byte_ready;
  assign hdr_count = {cnt_hi, byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt_hi       <= '0;
      n_words      <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
      word         <= '0;
      addr         <= '0;
      csum         <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_HDR_HI;
            done     <= 1'b0;
            error    <= 1'b0;
            csum     <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
          end
        end
        ST_HDR_HI: begin
          if (xfer) begin
            cnt_hi <= byte_in;
            state  <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer) begin
            n_words  <= hdr_count;
            addr     <= BASE_ADDR;
            word_cnt <= '0;
            byte_idx <= '0;
            csum     <= '0;
            if ({1'b0, hdr_count} > DEPTH_LIM) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (hdr_count == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            word     <= {word[23:0], byte_in};
            csum     <= csum ^ byte_in;
            byte_idx <= byte_idx + 2'd1;
            // The strobe is registered here so it is high for exactly the
            // one cycle spent in WRITE.
            if (byte_idx == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= addr;
              imem_wr_data <= {word[23:0], byte_in};
              state        <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          addr     <= addr + ADDR_STEP;
          word_cnt <= word_cnt + 16'd1;
          state    <= (word_cnt + 16'd1 == n_words) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (xfer) begin
            if (byte_in == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Testbench for instruction_memory_loader: directed frames plus random frames,
// with expected memory writes queued by the driver and checked by a monitor.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  instruction_memory_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] due;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         checks = 0;
  int         passes = 0;
  int         max_gap = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_wr_addr, imem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wr_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit last_of_word,
                           input logic [31:0] ea, input logic [31:0] ed, output bit ok);
    int n = 0;
    int gaps;
    gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gaps) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = byte_ready;
    if (ok && last_of_word) exp_q.push_back('{addr: ea, data: ed, due: 32'(cyc + 1)});
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  // Sends the frame in `frame`; stop_after >= 0 sends only that many bytes
  // and skips the end-of-frame checks.
  task automatic run_frame(input string tag, input int stop_after);
    int         n;
    int         nsend;
    logic [7:0] cs;
    bit         exp_done;
    bit         ok;
    n = {frame[0], frame[1]};
    if (n > 64) begin
      nsend    = 2;
      exp_done = 1'b0;
    end else begin
      nsend = 2 + 4 * n + 1;
      cs    = 8'h00;
      for (int i = 2; i < 2 + 4 * n; i++) cs ^= frame[i];
      exp_done = (cs == frame[nsend - 1]);
    end
    if (stop_after >= 0) nsend = stop_after;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_hold_on_start"}, 64'({cpu_hold, done, error}), 64'(3'b100));

    for (int i = 0; i < nsend; i++) begin
      bit          low;
      logic [31:0] ea;
      logic [31:0] ed;
      low = (i >= 2) && (i < 2 + 4 * n) && (((i - 2) % 4) == 3);
      ea  = 32'(4 * ((i - 2) / 4));
      ed  = low ? {frame[i - 3], frame[i - 2], frame[i - 1], frame[i]} : 32'h0;
      send_byte(frame[i], low, ea, ed, ok);
      if (!ok) begin
        checks++;
        $display("FAIL %s_ready_timeout: byte %0d never accepted, expected byte_ready=1", tag, i);
        return;
      end
    end
    if (stop_after >= 0) return;

    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(!exp_done));
    check({tag, "_hold_ready"}, 64'({cpu_hold, byte_ready}), 64'(2'b00));
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_case1();
    frame = '{8'h00, 8'h02, 8'h8B, 8'h02, 8'h00, 8'h20,
              8'hF8, 8'h40, 8'h00, 8'h01, 8'h10};
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_addr_data", {imem_wr_addr, imem_wr_data}, 64'd0);
    check("reset_flags", 64'({imem_wr_en, cpu_hold, done, error, byte_ready}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    load_case1();
    run_frame("case1", -1);

    frame[10] = 8'h11;
    run_frame("bad_csum", -1);

    frame = '{8'h00, 8'h41};
    run_frame("too_many", -1);

    max_gap = 5;
    load_case1();
    run_frame("gaps", -1);
    max_gap = 0;

    load_case1();
    run_frame("mid_reset", 8);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_addr_data", {imem_wr_addr, imem_wr_data}, 64'd0);
    check("mid_reset_flags", 64'({imem_wr_en, cpu_hold, done, error, byte_ready}), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_reset_pending", 64'(exp_q.size()), 64'd0);
    run_frame("after_reset", -1);

    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("empty_ok", -1);
    frame = '{8'h00, 8'h00, 8'h01};
    run_frame("empty_bad", -1);

    for (int f = 0; f < 20; f++) begin
      int         n;
      logic [7:0] cs;
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(70, 65)) : int'($urandom_range(8, 0));
      max_gap = int'($urandom_range(3, 0));
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      if (n <= 64) begin
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          cs ^= b;
          frame.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
        frame.push_back(cs);
      end
      run_frame("random", -1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
